// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared constants, bank-state enum and address helper for the MNIST pixel receiver
//
// Purpose: frame geometry, RAM sizing and the per-bank state encoding used by
//          mnist_pixel_rx, mnist_pixel_rx_if and mnist_pixel_ram.
// Ports:   none (package).
package mnist_pkg;

  localparam int PIXELS_PER_FRAME = 784;
  localparam int PIX_W            = 8;
  localparam int PIX_ADDR_W       = 10;

  // Two frame banks laid end to end in one RAM.
  localparam int RAM_DEPTH  = 2 * PIXELS_PER_FRAME;
  localparam int RAM_ADDR_W = 11;

  localparam logic [PIX_ADDR_W-1:0] LAST_PIX = PIX_ADDR_W'(PIXELS_PER_FRAME - 1);
  localparam logic [PIX_ADDR_W-1:0] FULL_CNT = PIX_ADDR_W'(PIXELS_PER_FRAME);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Bank 1 starts right after the last pixel of bank 0.
  function automatic logic [RAM_ADDR_W-1:0] bank_addr(input logic bank,
                                                       input logic [PIX_ADDR_W-1:0] offs);
    logic [RAM_ADDR_W-1:0] base;
    base = bank ? RAM_ADDR_W'(PIXELS_PER_FRAME) : '0;
    return base + RAM_ADDR_W'(offs);
  endfunction

endpackage

// File: rtl/mnist_pixel_rx_if.sv
// rtl/mnist_pixel_rx_if.sv - pixel burst input and frame consumer signals of the MNIST pixel receiver
//
// Purpose: bundles the producer-side burst (input_en, pixel_in) and the
//          consumer-side read/handshake signals into one port.
// Signals: input_en      producer burst strobe
//          pixel_in      8-bit grayscale pixel, row-major
//          frame_ready   complete frame held for consumer (level)
//          rd_addr       consumer pixel address 0..783
//          rd_data       registered pixel at rd_addr
//          frame_release consumer pulse freeing its bank
//          short_frame   one-cycle pulse, burst ended early
//          overrun       sticky, a burst was dropped
// Modports: slave (the receiver), master (producer/consumer side).
interface mnist_pixel_rx_if;
  import mnist_pkg::*;

  logic                  input_en;
  logic [PIX_W-1:0]      pixel_in;
  logic                  frame_ready;
  logic [PIX_ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]      rd_data;
  logic                  frame_release;
  logic                  short_frame;
  logic                  overrun;

  modport slave (
    input  input_en, pixel_in, rd_addr, frame_release,
    output frame_ready, rd_data, short_frame, overrun
  );

  modport master (
    output input_en, pixel_in, rd_addr, frame_release,
    input  frame_ready, rd_data, short_frame, overrun
  );

endinterface

// File: rtl/mnist_pixel_ram.sv
// rtl/mnist_pixel_ram.sv - simple dual-port 1568x8 frame store with registered read
//
// Purpose: holds both ping-pong frame banks; bank 1 occupies addresses 784..1567.
// Ports:   clk      rising-edge clock
//          we_i     write enable
//          waddr_i  write address (bank base + pixel offset)
//          wdata_i  write data
//          raddr_i  read address (bank base + pixel offset)
//          rdata_o  read data, one edge after raddr_i
// Contents are never cleared.
module mnist_pixel_ram
  import mnist_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [RAM_ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]      wdata_i,
  input  logic [RAM_ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]      rdata_o
);

  logic [PIX_W-1:0] mem_q [RAM_DEPTH];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mnist_pixel_rx.sv
// rtl/mnist_pixel_rx.sv - ping-pong MNIST frame receiver: burst detect, fill counter, bank states, pointers
//
// Purpose: accepts 784-pixel bursts into one of two banks while the consumer
//          reads the other; flags short bursts and dropped bursts.
// Ports:   clk  rising-edge clock
//          rst  synchronous active-high reset
//          bus  mnist_pixel_rx_if.slave (input_en, pixel_in, rd_addr,
//               frame_release in; frame_ready, rd_data, short_frame,
//               overrun out)
module mnist_pixel_rx
  import mnist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mnist_pixel_rx_if.slave   bus
);

  bank_state_e           bank_q [2];
  bank_state_e           bank_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [PIX_ADDR_W-1:0] cnt_q, cnt_d;
  logic                  active_q, active_d;
  logic                  short_q, short_d;
  logic                  overrun_q, overrun_d;
  logic                  en_q;
  logic                  rd_zero_q;

  logic                  burst_start;
  logic                  release_ok;
  logic                  frame_ready;
  logic                  rd_oob;
  logic                  ram_we;
  logic [PIX_ADDR_W-1:0] wr_offs;
  logic [RAM_ADDR_W-1:0] ram_waddr;
  logic [RAM_ADDR_W-1:0] ram_raddr;
  logic [PIX_W-1:0]      ram_rdata;

  assign frame_ready = (bank_q[rd_ptr_q] == FULL);
  assign burst_start = bus.input_en && !en_q;
  assign release_ok  = bus.frame_release && frame_ready;

  always_comb begin
    bank_d    = bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    short_d   = 1'b0;
    overrun_d = overrun_q;
    ram_we    = 1'b0;
    wr_offs   = cnt_q;

    if (burst_start) begin
      // Registered bank state is used, so a release on this same edge
      // cannot make its bank available to this burst.
      if (bank_q[wr_ptr_q] == EMPTY) begin
        ram_we           = 1'b1;
        wr_offs          = '0;
        bank_d[wr_ptr_q] = FILLING;
        active_d         = 1'b1;
        cnt_d            = PIX_ADDR_W'(1);
      end else begin
        overrun_d = 1'b1;
        active_d  = 1'b0;
      end
    end else if (active_q) begin
      if (bus.input_en) begin
        ram_we = 1'b1;
        cnt_d  = cnt_q + PIX_ADDR_W'(1);
        if (cnt_q == LAST_PIX) begin
          // Frame complete: counter rests at 784 and padding beats
          // fall outside any active burst.
          bank_d[wr_ptr_q] = FULL;
          wr_ptr_d         = ~wr_ptr_q;
          active_d         = 1'b0;
        end
      end else begin
        bank_d[wr_ptr_q] = EMPTY;
        active_d         = 1'b0;
        cnt_d            = '0;
        short_d          = 1'b1;
      end
    end

    // The writer only touches EMPTY/FILLING banks and the reader only a FULL
    // one, so both updates can land on the same edge without conflict.
    if (release_ok) begin
      bank_d[rd_ptr_q] = EMPTY;
      rd_ptr_d         = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    // Tracking input_en through reset keeps a burst that straddles reset
    // from restarting until input_en drops.
    en_q <= bus.input_en;
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      short_q   <= 1'b0;
      overrun_q <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      bank_q    <= bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      short_q   <= short_d;
      overrun_q <= overrun_d;
      rd_zero_q <= rd_oob;
    end
  end

  assign rd_oob    = (bus.rd_addr > LAST_PIX);
  assign ram_waddr = bank_addr(wr_ptr_q, wr_offs);
  assign ram_raddr = rd_oob ? '0 : bank_addr(rd_ptr_q, bus.rd_addr);

  mnist_pixel_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we && !rst),
    .waddr_i (ram_waddr),
    .wdata_i (bus.pixel_in),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Out-of-range reads and reads issued during reset return zero.
  assign bus.rd_data     = rd_zero_q ? '0 : ram_rdata;
  assign bus.frame_ready = frame_ready;
  assign bus.short_frame = short_q;
  assign bus.overrun     = overrun_q;

endmodule
